dcmac_tdm_stats_accum: RTL

DCMAC_TDM_STATS_ACCUM -- requirements
Module: dcmac_tdm_stats_accum

---
 rtl/dcmac_tdm_stats_accum.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dcmac_tdm_stats_accum.sv
// dcmac_tdm_stats_accum: per-channel TDM statistics accumulator.
// Each channel owns NUM_STATS live counters, which advance on increment beats,
// and NUM_STATS snapshot counters, which capture live on a PM tick.
// Reads return snapshot data only, as 32-bit words, one cycle after i_rd_en.
// Optional feature macro: DCMAC_STATS_SAT_EN. When defined, live counters
// saturate at all-ones. When undefined, live counters wrap.
module dcmac_tdm_stats_accum #(
  parameter  int unsigned NUM_CH    = 6,
  parameter  int unsigned NUM_STATS = 8,
  parameter  int unsigned INC_W     = 8,
  parameter  int unsigned CNT_W     = 48,
  localparam int unsigned ID_W      = 6,
  localparam int unsigned IDX_W     = 5,
  localparam int unsigned RD_W      = 32
) (
  input  logic                       stats_clk,
  input  logic                       stats_rst,
  input  logic                       ts_rst,
  input  logic [ID_W-1:0]            ts_rst_id,
  input  logic                       i_tdm_stats_valid,
  input  logic [ID_W-1:0]            i_tdm_stats_id,
  input  logic [NUM_STATS*INC_W-1:0] i_tdm_stats,
  input  logic [NUM_CH-1:0]          i_pm_tick,
  input  logic                       i_rd_en,
  input  logic [ID_W-1:0]            i_rd_id,
  input  logic [IDX_W-1:0]           i_rd_index,
  input  logic                       i_rd_h,
  output logic                       o_init,
  output logic [RD_W-1:0]            o_cnt,
  output logic                       o_cnt_vld
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q;
  logic [ID_W-1:0]       sweep_idx_q;

  logic [CNT_W-1:0]      live_q [NUM_CH][NUM_STATS];
  logic [CNT_W-1:0]      snap_q [NUM_CH][NUM_STATS];
  logic [CNT_W-1:0]      sum_c  [NUM_CH][NUM_STATS];

  logic [NUM_CH-1:0]     inc_hit_c;
  logic [NUM_CH-1:0]     clr_hit_c;
  logic [NUM_CH-1:0]     sweep_hit_c;
  logic [NUM_CH-1:0]     tick_c;
  logic [CNT_W-1:0]      inc_v;
`ifdef DCMAC_STATS_SAT_EN
  logic [CNT_W:0]        ext_v;
`endif
  logic [RD_W-1:0]       rd_data_c;

  // Init/run sequencer: sweeps one channel per cycle after reset, then runs.
  always_ff @(posedge stats_clk or posedge stats_rst) begin
    if (stats_rst) begin
      state_q     <= ST_INIT;
      sweep_idx_q <= '0;
      o_init      <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (sweep_idx_q == ID_W'(NUM_CH - 1)) begin
            state_q     <= ST_RUN;
            sweep_idx_q <= '0;
            o_init      <= 1'b0;
          end else begin
            sweep_idx_q <= sweep_idx_q + ID_W'(1);
            o_init      <= 1'b1;
          end
        end
        ST_RUN: begin
          o_init <= 1'b0;
        end
        default: begin
          state_q     <= ST_INIT;
          sweep_idx_q <= '0;
          o_init      <= 1'b1;
        end
      endcase
    end
  end

  // Per-channel event decode; beats and ticks are ignored while sweeping.
  always_comb begin
    inc_hit_c   = '0;
    clr_hit_c   = '0;
    sweep_hit_c = '0;
    tick_c      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      inc_hit_c[c]   = i_tdm_stats_valid && !o_init && (i_tdm_stats_id == ID_W'(c));
      clr_hit_c[c]   = ts_rst && (ts_rst_id == ID_W'(c));
      sweep_hit_c[c] = o_init && (sweep_idx_q == ID_W'(c));
      tick_c[c]      = i_pm_tick[c] && !o_init;
    end
  end

  // Live counter plus this cycle's increment (saturating or wrapping).
  always_comb begin
    inc_v = '0;
`ifdef DCMAC_STATS_SAT_EN
    ext_v = '0;
`endif
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned s = 0; s < NUM_STATS; s++) begin
        inc_v = inc_hit_c[c] ? CNT_W'(i_tdm_stats[s*INC_W +: INC_W]) : '0;
`ifdef DCMAC_STATS_SAT_EN
        ext_v       = {1'b0, live_q[c][s]} + {1'b0, inc_v};
        sum_c[c][s] = ext_v[CNT_W] ? {CNT_W{1'b1}} : ext_v[CNT_W-1:0];
`else
        sum_c[c][s] = live_q[c][s] + inc_v;
`endif
      end
    end
  end

  // Counter banks. The sweep defines contents, so no reset is needed.
  // A tick moves live+inc into the snapshot and zeroes live atomically.
  // A tick also overrides a same-cycle clear, so the increment is kept.
  always_ff @(posedge stats_clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned s = 0; s < NUM_STATS; s++) begin
        if (sweep_hit_c[c]) begin
          live_q[c][s] <= '0;
          snap_q[c][s] <= '0;
        end else if (tick_c[c]) begin
          snap_q[c][s] <= sum_c[c][s];
          live_q[c][s] <= '0;
        end else if (clr_hit_c[c]) begin
          live_q[c][s] <= '0;
        end else begin
          live_q[c][s] <= sum_c[c][s];
        end
      end
    end
  end

  // Snapshot read mux. Out-of-range ids and indices, or reads during init, yield 0.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned s = 0; s < NUM_STATS; s++) begin
        if ((i_rd_id == ID_W'(c)) && (i_rd_index == IDX_W'(s))) begin
          rd_data_c = i_rd_h ? RD_W'(snap_q[c][s][CNT_W-1:32]) : snap_q[c][s][31:0];
        end
      end
    end
    if (o_init) begin
      rd_data_c = '0;
    end
  end

  // Registered read response; data holds between reads.
  always_ff @(posedge stats_clk or posedge stats_rst) begin
    if (stats_rst) begin
      o_cnt     <= '0;
      o_cnt_vld <= 1'b0;
    end else begin
      o_cnt_vld <= i_rd_en;
      if (i_rd_en) begin
        o_cnt <= rd_data_c;
      end
    end
  end

endmodule
